// File: rtl/arq_frame_receiver.sv
// Serial ARQ frame receiver: deserializes start+header+payload+CRC-8 frames,
// suppresses bad/duplicate frames, drains payload bytes and answers ACK/NAK.
module arq_frame_receiver #(
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter logic [7:0]  CRC_POLY      = 8'h07
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_arq_en,
  input  logic       i_otn_rx_data,
  output logic       o_otn_tx_ack,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic [7:0] o_crc_val,
  output logic       o_crc_err,
  output logic       o_overrun
);

  localparam int unsigned FRAME_BITS = 8 * (PAYLOAD_BYTES + 2);
  localparam int unsigned CRC_BITS   = 8 * (PAYLOAD_BYTES + 1);
  // Only the seq bit of the header is kept; its upper 7 bits fall off the top.
  localparam int unsigned SHIFT_W    = CRC_BITS + 1;
  localparam int unsigned BIT_CW     = $clog2(FRAME_BITS);
  localparam int unsigned BYTE_CW    = $clog2(PAYLOAD_BYTES + 1);

  localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(FRAME_BITS - 1);
  localparam logic [BIT_CW-1:0]  CRC_END   = BIT_CW'(CRC_BITS);
  localparam logic [BYTE_CW-1:0] LAST_BYTE = BYTE_CW'(PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_CHECK,
    ST_DRAIN,
    ST_ACK_TX
  } state_e;

  state_e               state_q,    state_d;
  logic [BIT_CW-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [BYTE_CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [SHIFT_W-1:0]   shift_q,    shift_d;
  logic [7:0]           crc_q,      crc_d;
  logic [7:0]           crc_val_q,  crc_val_d;
  logic                 crc_err_q,  crc_err_d;
  logic                 overrun_q,  overrun_d;
  logic                 arq_q,      arq_d;
  logic                 exp_seq_q,  exp_seq_d;
  logic [2:0]           ack_sr_q,   ack_sr_d;
  logic [1:0]           ack_cnt_q,  ack_cnt_d;
  logic                 rx_prev_q;

  logic rx_seq;
  logic crc_good;
  logic busy;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

  assign rx_seq   = shift_q[SHIFT_W-1];
  assign crc_good = (crc_q == shift_q[7:0]);
  assign busy     = (state_q == ST_CHECK) || (state_q == ST_DRAIN) || (state_q == ST_ACK_TX);

  // NOTE: every next-state signal gets its default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    crc_val_d  = crc_val_q;
    crc_err_d  = 1'b0;
    overrun_d  = 1'b0;
    arq_d      = arq_q;
    exp_seq_d  = exp_seq_q;
    ack_sr_d   = ack_sr_q;
    ack_cnt_d  = ack_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (!i_otn_rx_data) begin
          state_d   = ST_RX;
          arq_d     = i_arq_en;
          bit_cnt_d = '0;
          crc_d     = '0;
        end
      end

      ST_RX: begin
        shift_d = {shift_q[SHIFT_W-2:0], i_otn_rx_data};
        if (bit_cnt_q < CRC_END) begin
          crc_d = crc8_step(crc_q, i_otn_rx_data);
        end
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_CHECK;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CW'(1);
        end
      end

      ST_CHECK: begin
        crc_val_d  = crc_q;
        byte_cnt_d = '0;
        ack_cnt_d  = '0;
        if (!crc_good) begin
          // NAK reports the sequence number we are still waiting for.
          crc_err_d = 1'b1;
          ack_sr_d  = {1'b0, 1'b0, exp_seq_q};
          state_d   = arq_q ? ST_ACK_TX : ST_IDLE;
        end else begin
          ack_sr_d = {1'b0, 1'b1, rx_seq};
          if (!arq_q) begin
            state_d = ST_DRAIN;
          end else if (rx_seq == exp_seq_q) begin
            exp_seq_d = ~exp_seq_q;
            state_d   = ST_DRAIN;
          end else begin
            state_d = ST_ACK_TX;
          end
        end
      end

      ST_DRAIN: begin
        if (i_byte_ready) begin
          // Shift the next payload byte into the output slot.
          shift_d = {shift_q[SHIFT_W-9:0], 8'h00};
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = arq_q ? ST_ACK_TX : ST_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + BYTE_CW'(1);
          end
        end
      end

      ST_ACK_TX: begin
        ack_sr_d = {ack_sr_q[1:0], 1'b1};
        if (ack_cnt_q == 2'd2) begin
          state_d = ST_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 2'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (busy && !i_otn_rx_data && rx_prev_q) begin
      overrun_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      // NOTE: the frame buffer is reset because it drives o_byte_data directly,
      // and a reset must also discard any partially received frame.
      shift_q    <= '0;
      crc_q      <= '0;
      crc_val_q  <= '0;
      crc_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
      arq_q      <= 1'b0;
      exp_seq_q  <= 1'b0;
      ack_sr_q   <= 3'b111;
      ack_cnt_q  <= '0;
      rx_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      crc_val_q  <= crc_val_d;
      crc_err_q  <= crc_err_d;
      overrun_q  <= overrun_d;
      arq_q      <= arq_d;
      exp_seq_q  <= exp_seq_d;
      ack_sr_q   <= ack_sr_d;
      ack_cnt_q  <= ack_cnt_d;
      rx_prev_q  <= i_otn_rx_data;
    end
  end

  assign o_otn_tx_ack = (state_q == ST_ACK_TX) ? ack_sr_q[2] : 1'b1;
  assign o_byte_valid = (state_q == ST_DRAIN);
  assign o_byte_data  = shift_q[CRC_BITS-1 -: 8];
  assign o_crc_val    = crc_val_q;
  assign o_crc_err    = crc_err_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_arq_frame_receiver.sv
// Directed bench for arq_frame_receiver: table of frames with hand-computed
// CRC/ACK results, plus reset-mid-frame and backpressure/overrun sequences.
module tb_arq_frame_receiver;

  localparam int P = 4;

  logic       clk, rst, arq_en, rx, ready;
  logic       ack, valid, crc_err, overrun;
  logic [7:0] data, crc_val;

  arq_frame_receiver #(.PAYLOAD_BYTES(P), .CRC_POLY(8'h07)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_arq_en      (arq_en),
    .i_otn_rx_data (rx),
    .o_otn_tx_ack  (ack),
    .o_byte_data   (data),
    .o_byte_valid  (valid),
    .i_byte_ready  (ready),
    .o_crc_val     (crc_val),
    .o_crc_err     (crc_err),
    .o_overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        arq;
    logic [7:0]  hdr;
    logic [31:0] payload;
    logic [7:0]  crc;
    int          n_bytes;
    int          first_lat;
    int          span;
    logic [7:0]  crc_val;
    int          n_err;
    int          n_ack;
    logic [2:0]  ack_bits;
    int          ack_lat;
    int          n_ovr;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int last_bit = 0;

  // Cycle-based monitor: everything observed on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  logic [7:0] stall_q[$];
  logic [2:0] ack_q[$];
  int         ack_cyc_q[$];
  logic       ack_tail_q[$];
  int         err_n = 0;
  int         ovr_n = 0;
  int         ack_phase = 0;
  logic [2:0] ack_cur = 3'b000;

  always @(negedge clk) begin
    if (!rst) begin
      ack_phase = 0;
    end else begin
      if (valid && ready) begin
        got_q.push_back(data);
        got_cyc_q.push_back(cyc);
      end else if (valid) begin
        stall_q.push_back(data);
      end
      if (crc_err) err_n++;
      if (overrun) ovr_n++;
      case (ack_phase)
        0: if (!ack) begin
             ack_cur = 3'b000;
             ack_cyc_q.push_back(cyc);
             ack_phase = 1;
           end
        1: begin ack_cur[1] = ack; ack_phase = 2; end
        2: begin ack_cur[0] = ack; ack_q.push_back(ack_cur); ack_phase = 3; end
        default: begin ack_tail_q.push_back(ack); ack_phase = 0; end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic arq, input logic [7:0] hdr, input logic [7:0] crc,
                              input int n_bytes, input logic [7:0] cval, input int n_err,
                              input int n_ack, input logic [2:0] abits, input int alat);
    vec_t v;
    v.arq = arq; v.hdr = hdr; v.payload = 32'h4865_6C6F; v.crc = crc;
    v.n_bytes = n_bytes; v.first_lat = 2; v.span = 3; v.crc_val = cval;
    v.n_err = n_err; v.n_ack = n_ack; v.ack_bits = abits; v.ack_lat = alat; v.n_ovr = 0;
    return v;
  endfunction

  task automatic send_frame(input vec_t v);
    logic [47:0] bits;
    bits = {v.hdr, v.payload, v.crc};
    @(posedge clk); #1;
    arq_en = v.arq;
    rx     = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      @(posedge clk); #1;
      rx = bits[i];
    end
    last_bit = cyc;
    @(posedge clk); #1;
    rx = 1'b1;
  endtask

  task automatic check_result(input string name, input vec_t v, input int gb,
                              input int ab, input int eb, input int ob);
    int n;
    logic [7:0] exp_b;
    n = got_q.size() - gb;
    check($sformatf("%s byte_count", name), n, v.n_bytes);
    for (int b = 0; b < v.n_bytes; b++) begin
      exp_b = 8'(v.payload >> (24 - 8 * b));
      check($sformatf("%s byte%0d", name, b),
            (b < n) ? 32'(got_q[gb + b]) : 32'hFFFF_FFFF, 32'(exp_b));
    end
    if (v.n_bytes > 0 && n > 0) begin
      check($sformatf("%s first_byte_latency", name), got_cyc_q[gb] - last_bit, v.first_lat);
      check($sformatf("%s drain_span", name), got_cyc_q[gb + n - 1] - got_cyc_q[gb], v.span);
    end
    check($sformatf("%s crc_val", name), crc_val, v.crc_val);
    check($sformatf("%s crc_err_cycles", name), err_n - eb, v.n_err);
    check($sformatf("%s ack_count", name), ack_q.size() - ab, v.n_ack);
    if (v.n_ack > 0 && ack_q.size() > ab) begin
      check($sformatf("%s ack_bits", name), ack_q[ab], v.ack_bits);
      check($sformatf("%s ack_latency", name), ack_cyc_q[ab] - last_bit, v.ack_lat);
      if (ack_tail_q.size() > ab) check($sformatf("%s ack_tail", name), ack_tail_q[ab], 1);
      else check($sformatf("%s ack_tail_seen", name), 0, 1);
    end
    check($sformatf("%s overrun_cycles", name), ovr_n - ob, v.n_ovr);
  endtask

  task automatic check_reset_values(input string name);
    check($sformatf("%s ack", name), ack, 1);
    check($sformatf("%s valid", name), valid, 0);
    check($sformatf("%s data", name), data, 0);
    check($sformatf("%s crc_val", name), crc_val, 0);
    check($sformatf("%s crc_err", name), crc_err, 0);
    check($sformatf("%s overrun", name), overrun, 0);
  endtask

  vec_t vecs[11];
  vec_t v;
  int   gb, ab, eb, ob, sb;
  logic [47:0] fbits;
  logic [6:0]  rdy_pat;

  initial begin
    // Expected-seq evolution: 0 -> (NAK) 0 -> accept 1 -> dup 1 -> NAK 1 ->
    // non-ARQ 1 -> 1 -> accept seq1 0 -> accept seq0 1 -> non-ARQ 1 -> accept 0 -> accept 1
    vecs[0]  = mk(1'b1, 8'h00, 8'h2C, 0, 8'h2D, 1, 1, 3'b000, 2);
    vecs[1]  = mk(1'b1, 8'h00, 8'h2D, 4, 8'h2D, 0, 1, 3'b010, 6);
    vecs[2]  = mk(1'b1, 8'h00, 8'h2D, 0, 8'h2D, 0, 1, 3'b010, 2);
    vecs[3]  = mk(1'b1, 8'h00, 8'h2C, 0, 8'h2D, 1, 1, 3'b001, 2);
    vecs[4]  = mk(1'b0, 8'h00, 8'h2D, 4, 8'h2D, 0, 0, 3'b000, 0);
    vecs[5]  = mk(1'b0, 8'h00, 8'h2C, 0, 8'h2D, 1, 0, 3'b000, 0);
    vecs[6]  = mk(1'b1, 8'h01, 8'h4F, 4, 8'h4F, 0, 1, 3'b011, 6);
    vecs[7]  = mk(1'b1, 8'h00, 8'h2D, 4, 8'h2D, 0, 1, 3'b010, 6);
    vecs[8]  = mk(1'b0, 8'h01, 8'h4F, 4, 8'h4F, 0, 0, 3'b000, 0);
    vecs[9]  = mk(1'b1, 8'h01, 8'h4F, 4, 8'h4F, 0, 1, 3'b011, 6);
    vecs[10] = mk(1'b1, 8'h00, 8'h2D, 4, 8'h2D, 0, 1, 3'b010, 6);

    rst    = 1'b0;
    rx     = 1'b1;
    ready  = 1'b1;
    arq_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      v  = vecs[i];
      gb = got_q.size(); ab = ack_q.size(); eb = err_n; ob = ovr_n;
      send_frame(v);
      repeat (14) @(posedge clk);
      #1;
      check_result($sformatf("vec%0d", i), v, gb, ab, eb, ob);
    end

    // Reset in the middle of a frame, with expected_seq currently 1.
    fbits = {8'h00, 32'h4865_6C6F, 8'h2D};
    @(posedge clk); #1;
    arq_en = 1'b1;
    rx     = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      rx = fbits[47 - k];
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rx  = 1'b1;
    #1;
    check_reset_values("mid_rx_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    v  = mk(1'b1, 8'h00, 8'h2D, 4, 8'h2D, 0, 1, 3'b010, 6);
    gb = got_q.size(); ab = ack_q.size(); eb = err_n; ob = ovr_n;
    send_frame(v);
    repeat (14) @(posedge clk);
    #1;
    check_result("after_reset", v, gb, ab, eb, ob);

    // Backpressure during drain plus a start bit on the link while draining.
    v = mk(1'b1, 8'h01, 8'h4F, 4, 8'h4F, 0, 1, 3'b011, 9);
    v.first_lat = 4;
    v.span      = 4;
    v.n_ovr     = 1;
    rdy_pat = 7'b0010111;
    gb = got_q.size(); ab = ack_q.size(); eb = err_n; ob = ovr_n; sb = stall_q.size();
    ready = 1'b0;
    send_frame(v);
    for (int p = 0; p < 7; p++) begin
      @(posedge clk); #1;
      ready = rdy_pat[6 - p];
      if (p == 1) rx = 1'b0;
      if (p == 2) rx = 1'b1;
    end
    repeat (10) @(posedge clk);
    #1;
    check_result("backpressure", v, gb, ab, eb, ob);
    check("backpressure stall_count", stall_q.size() - sb, 3);
    if (stall_q.size() - sb == 3) begin
      check("backpressure stall0", stall_q[sb],     8'h48);
      check("backpressure stall1", stall_q[sb + 1], 8'h48);
      check("backpressure stall2", stall_q[sb + 2], 8'h65);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
